sys_resp_ctrl: RTL and testbench

SYS_RESP_CTRL -- requirements
Module: sys_resp_ctrl

---
 rtl/sys_resp_ctrl_pkg.sv | 19 +
 rtl/sys_resp_ctrl.sv | 123 ++++++++++++
 tb/tb_sys_resp_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_resp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sys_resp_ctrl_pkg
// Shared definitions for the system response controller: default data and
// ALU widths, the TX byte counter width, and the controller state encoding.
// ---------------------------------------------------------------------------
package sys_resp_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ALU_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;
   localparam int TX_CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_RF = 2'd1,
      SEND_LO = 2'd2,
      SEND_HI = 2'd3
   } resp_state_t;

endpackage

// File: rtl/sys_resp_ctrl.sv
// ---------------------------------------------------------------------------
// sys_resp_ctrl
// Collects responses from the ALU (two bytes, low first) or the register
// file (one byte) and streams them into an async FIFO, honouring its full
// flag. Responses arriving while a previous one is still being sent are
// discarded and flagged with a one-cycle DROP pulse.
//
// Ports
//   CLK           in   REF_CLK domain clock
//   RST           in   asynchronous active-low reset
//   ALU_OUT       in   ALU result, qualified by OUT_VALID
//   OUT_VALID     in   one-cycle pulse qualifying ALU_OUT
//   RdData        in   register-file read data, qualified by RdData_Valid
//   RdData_Valid  in   one-cycle pulse qualifying RdData
//   F_FULL        in   FIFO write-side full flag
//   WR_DATA       out  byte presented to the FIFO (0 when idle)
//   W_INC         out  FIFO write strobe, one byte per high cycle
//   CTRL_BUSY     out  registered, high while not IDLE
//   DROP          out  one-cycle pulse when a response is discarded
//   TX_CNT        out  wrapping count of bytes written to the FIFO
// ---------------------------------------------------------------------------
module sys_resp_ctrl
   import sys_resp_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ALU_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_VALID,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   input  logic                  F_FULL,
   output logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  W_INC,
   output logic                  CTRL_BUSY,
   output logic                  DROP,
   output logic [TX_CNT_W-1:0]   TX_CNT
);

   resp_state_t            state_q;
   resp_state_t            state_nxt;
   logic [ALU_WIDTH-1:0]   alu_hold_q;
   logic [DATA_WIDTH-1:0]  rf_hold_q;
   logic [TX_CNT_W-1:0]    tx_cnt_q;
   logic                   drop_q;
   logic                   busy_q;
   logic                   is_idle;
   logic                   wr_fire;
   logic                   drop_nxt;

   assign is_idle = (state_q == IDLE);
   assign wr_fire = !is_idle && !F_FULL;

   // A response is lost either because the FSM is busy, or because both
   // sources fired together in IDLE and the ALU result took priority.
   assign drop_nxt = is_idle ? (OUT_VALID && RdData_Valid)
                             : (OUT_VALID || RdData_Valid);

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy_q  <= (state_nxt != IDLE);
      end
   end

   // Next-state logic: send states only advance on an actual FIFO write
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         IDLE: begin
            if (OUT_VALID)
               state_nxt = SEND_LO;
            else if (RdData_Valid)
               state_nxt = SEND_RF;
         end
         SEND_RF: if (wr_fire) state_nxt = IDLE;
         SEND_LO: if (wr_fire) state_nxt = SEND_HI;
         SEND_HI: if (wr_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: byte-select mux and write strobe
   always_comb begin
      W_INC   = wr_fire;
      WR_DATA = '0;
      unique case (state_q)
         SEND_RF: WR_DATA = rf_hold_q;
         SEND_LO: WR_DATA = alu_hold_q[DATA_WIDTH-1:0];
         SEND_HI: WR_DATA = alu_hold_q[ALU_WIDTH-1:DATA_WIDTH];
         default: WR_DATA = '0;
      endcase
   end

   // Holding registers, drop pulse and byte counter
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         alu_hold_q <= '0;
         rf_hold_q  <= '0;
         tx_cnt_q   <= '0;
         drop_q     <= 1'b0;
      end else begin
         drop_q <= drop_nxt;
         if (is_idle && OUT_VALID)
            alu_hold_q <= ALU_OUT;
         else if (is_idle && RdData_Valid)
            rf_hold_q <= RdData;
         if (wr_fire)
            tx_cnt_q <= tx_cnt_q + 1'b1;
      end
   end

   assign CTRL_BUSY = busy_q;
   assign DROP      = drop_q;
   assign TX_CNT    = tx_cnt_q;

endmodule

// File: tb/tb_sys_resp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_resp_ctrl
// Directed scenarios followed by random traffic for sys_resp_ctrl. A
// transaction-level model holds the bytes still owed to the FIFO in a queue;
// every cycle the DUT outputs are compared against that model.
// ---------------------------------------------------------------------------
module tb_sys_resp_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        OUT_VALID = 1'b0;
   logic [7:0]  RdData = '0;
   logic        RdData_Valid = 1'b0;
   logic        F_FULL = 1'b0;
   logic [7:0]  WR_DATA;
   logic        W_INC;
   logic        CTRL_BUSY;
   logic        DROP;
   logic [7:0]  TX_CNT;

   sys_resp_ctrl #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ALU_OUT      (ALU_OUT),
      .OUT_VALID    (OUT_VALID),
      .RdData       (RdData),
      .RdData_Valid (RdData_Valid),
      .F_FULL       (F_FULL),
      .WR_DATA      (WR_DATA),
      .W_INC        (W_INC),
      .CTRL_BUSY    (CTRL_BUSY),
      .DROP         (DROP),
      .TX_CNT       (TX_CNT)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int fails   = 0;

   // reference model: bytes still to be written, byte count, pending drop
   logic [7:0] q[$];
   int         m_cnt  = 0;
   bit         m_drop = 1'b0;

   // observed event counters used by scenario-level checks
   int obs_wr   = 0;
   int obs_drop = 0;
   int obs_busy = 0;
   logic [7:0] wr_log[$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      obs_wr = 0; obs_drop = 0; obs_busy = 0;
      wr_log.delete();
   endtask

   // One clock cycle: apply inputs at the falling edge, check, advance model.
   task automatic step(input bit ov, input logic [15:0] alu, input bit rv,
                       input logic [7:0] rd, input bit ff);
      bit busy;
      bit drop_n;
      OUT_VALID = ov; ALU_OUT = alu; RdData_Valid = rv; RdData = rd; F_FULL = ff;
      #1;
      busy = (q.size() != 0);
      chk("busy",    {15'd0, CTRL_BUSY}, {15'd0, busy});
      chk("w_inc",   {15'd0, W_INC},     {15'd0, busy && !ff});
      chk("wr_data", {8'd0, WR_DATA},    {8'd0, busy ? q[0] : 8'd0});
      chk("tx_cnt",  {8'd0, TX_CNT},     m_cnt[15:0]);
      chk("drop",    {15'd0, DROP},      {15'd0, m_drop});
      if (W_INC) begin obs_wr++; wr_log.push_back(WR_DATA); end
      if (DROP) obs_drop++;
      if (CTRL_BUSY) obs_busy++;
      drop_n = 1'b0;
      if (!busy) begin
         if (ov) begin
            q.push_back(alu[7:0]);
            q.push_back(alu[15:8]);
            drop_n = rv;
         end else if (rv) begin
            q.push_back(rd);
         end
      end else begin
         drop_n = ov || rv;
         if (!ff) begin
            void'(q.pop_front());
            m_cnt = (m_cnt + 1) % 256;
         end
      end
      @(posedge CLK);
      m_drop = drop_n;
      @(negedge CLK);
   endtask

   task automatic idle(input int n, input bit ff);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 8'h0, ff);
   endtask

   // Reset asserted between edges; outputs must drop without a clock.
   task automatic do_reset();
      RST = 1'b0;
      OUT_VALID = 1'b0; RdData_Valid = 1'b0; F_FULL = 1'b0;
      #1;
      chk("rst_w_inc",   {15'd0, W_INC},     16'd0);
      chk("rst_wr_data", {8'd0, WR_DATA},    16'd0);
      chk("rst_busy",    {15'd0, CTRL_BUSY}, 16'd0);
      chk("rst_tx_cnt",  {8'd0, TX_CNT},     16'd0);
      chk("rst_drop",    {15'd0, DROP},      16'd0);
      q.delete(); m_cnt = 0; m_drop = 1'b0;
      @(posedge CLK); @(negedge CLK);
      @(posedge CLK); @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      @(negedge CLK);
      do_reset();

      // ALU response A55A, FIFO ready
      clear_obs();
      step(1'b1, 16'hA55A, 1'b0, 8'h0, 1'b0);
      idle(3, 1'b0);
      chk("alu_wr_count", obs_wr[15:0], 16'd2);
      chk("alu_byte_lo", {8'd0, wr_log[0]}, 16'h5A);
      chk("alu_byte_hi", {8'd0, wr_log[1]}, 16'hA5);
      chk("alu_tx_cnt", {8'd0, TX_CNT}, 16'd2);
      chk("alu_idle", {15'd0, CTRL_BUSY}, 16'd0);

      // RF response 3C
      clear_obs();
      step(1'b0, 16'h0, 1'b1, 8'h3C, 1'b0);
      idle(3, 1'b0);
      chk("rf_wr_count", obs_wr[15:0], 16'd1);
      chk("rf_byte", {8'd0, wr_log[0]}, 16'h3C);
      chk("rf_busy_cycles", obs_busy[15:0], 16'd1);

      // ALU 1234 with FIFO full for 5 cycles after capture
      clear_obs();
      step(1'b1, 16'h1234, 1'b0, 8'h0, 1'b0);
      idle(5, 1'b1);
      chk("stall_no_write", obs_wr[15:0], 16'd0);
      chk("stall_wr_data", {8'd0, WR_DATA}, 16'h34);
      idle(3, 1'b0);
      chk("stall_wr_count", obs_wr[15:0], 16'd2);
      chk("stall_byte_lo", {8'd0, wr_log[0]}, 16'h34);
      chk("stall_byte_hi", {8'd0, wr_log[1]}, 16'h12);

      // Simultaneous ALU and RF valid: ALU wins, one drop
      clear_obs();
      step(1'b1, 16'hBEEF, 1'b1, 8'h77, 1'b0);
      idle(4, 1'b0);
      chk("coll_wr_count", obs_wr[15:0], 16'd2);
      chk("coll_byte_lo", {8'd0, wr_log[0]}, 16'hEF);
      chk("coll_byte_hi", {8'd0, wr_log[1]}, 16'hBE);
      chk("coll_drop_count", obs_drop[15:0], 16'd1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(3) == 0, 16'($urandom), $urandom_range(3) == 0,
              8'($urandom), $urandom_range(2) == 0);
      idle(12, 1'b0);

      // TX_CNT wrap: 254 bytes preloaded, then one more ALU response
      @(negedge CLK);
      do_reset();
      for (int i = 0; i < 127; i++) begin
         step(1'b1, 16'(i * 257 + 3), 1'b0, 8'h0, 1'b0);
         idle(2, 1'b0);
      end
      chk("preload_tx_cnt", {8'd0, TX_CNT}, 16'd254);
      step(1'b1, 16'hCAFE, 1'b0, 8'h0, 1'b0);
      idle(3, 1'b0);
      chk("wrap_tx_cnt", {8'd0, TX_CNT}, 16'd0);

      // Reset during SEND_HI aborts the high byte
      step(1'b1, 16'h9966, 1'b0, 8'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
      chk("pre_rst_hi_byte", {8'd0, WR_DATA}, 16'h99);
      do_reset();
      clear_obs();
      @(negedge CLK);
      idle(4, 1'b0);
      chk("post_rst_no_write", obs_wr[15:0], 16'd0);

      // Response right after reset release is accepted
      clear_obs();
      step(1'b0, 16'h0, 1'b1, 8'h5C, 1'b0);
      idle(2, 1'b0);
      chk("post_rst_rf_byte", {8'd0, wr_log.size() > 0 ? wr_log[0] : 8'h00}, 16'h5C);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
